// File: rtl/i2s_codec_responder_if.sv
// I2S pin bundle between a bit-clock master and a codec-side responder.
// Master drives LRCLK/SCLK/SD_in; the codec (slave) drives SD_out.
interface i2s_codec_responder_if;
    logic LRCLK;
    logic SCLK;
    logic SD_in;
    logic SD_out;

    modport master (
        output LRCLK,
        output SCLK,
        output SD_in,
        input  SD_out
    );

    modport slave (
        input  LRCLK,
        input  SCLK,
        input  SD_in,
        output SD_out
    );
endinterface

// File: rtl/i2s_codec_responder.sv
// i2s_codec_responder: codec-side I2S endpoint clocked on the system clock.
// Ports: clk, RESET (sync, active high); i2s (slave: LRCLK/SCLK/SD_in in,
//   SD_out out); left_tx/right_tx in, tx_req out; left_rx/right_rx,
//   rx_valid, frame_err out.
module i2s_codec_responder #(
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   RESET,
    i2s_codec_responder_if.slave   i2s,
    input  logic [DATA_W-1:0]      left_tx,
    input  logic [DATA_W-1:0]      right_tx,
    output logic                   tx_req,
    output logic [DATA_W-1:0]      left_rx,
    output logic [DATA_W-1:0]      right_rx,
    output logic                   rx_valid,
    output logic                   frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    state_t state;

    logic [1:0] lr_sync;
    logic [2:0] sclk_sync;
    logic [1:0] sd_sync;

    logic lr_s;
    logic sd_s;
    logic sclk_rise;
    logic sclk_fall;
    logic lr_last;
    logic slot_start;

    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold_r;
    logic [CNT_W-1:0]  tx_cnt;
    logic              sd_out_q;

    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              rx_arm;
    logic [DATA_W-1:0] pend_l;
    logic              pend_ok;

    assign lr_s      = lr_sync[1];
    assign sd_s      = sd_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];

    // A slot begins on the SCLK fall where word select has moved.
    assign slot_start = sclk_fall && (lr_s != lr_last);

    assign rx_next = {rx_shift[DATA_W-2:0], sd_s};

    assign i2s.SD_out = sd_out_q;

    always_ff @(posedge clk) begin
        if (RESET) begin
            lr_sync   <= '0;
            sclk_sync <= '0;
            sd_sync   <= '0;
            lr_last   <= 1'b0;
            state     <= IDLE;
            tx_shift  <= '0;
            hold_r    <= '0;
            tx_cnt    <= '0;
            sd_out_q  <= 1'b0;
            tx_req    <= 1'b0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_arm    <= 1'b0;
            pend_l    <= '0;
            pend_ok   <= 1'b0;
            left_rx   <= '0;
            right_rx  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            lr_sync   <= {lr_sync[0], i2s.LRCLK};
            sclk_sync <= {sclk_sync[1:0], i2s.SCLK};
            sd_sync   <= {sd_sync[0], i2s.SD_in};

            tx_req    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (sclk_fall) begin
                lr_last <= lr_s;
            end

            if (slot_start) begin
                // The start fall itself only clears; the MSB goes out on
                // the next fall (one-bit delay).
                bit_cnt  <= '0;
                rx_arm   <= 1'b0;
                tx_cnt   <= '0;
                sd_out_q <= 1'b0;
                unique case (state)
                    IDLE: begin
                        // Only a falling word select can leave IDLE, so
                        // a partial right slot after reset is skipped.
                        if (!lr_s) begin
                            state    <= LEFT;
                            tx_shift <= left_tx;
                            hold_r   <= right_tx;
                            tx_req   <= 1'b1;
                            pend_ok  <= 1'b0;
                        end
                    end
                    LEFT: begin
                        state     <= RIGHT;
                        tx_shift  <= hold_r;
                        frame_err <= (bit_cnt != FULL);
                    end
                    RIGHT: begin
                        state     <= LEFT;
                        tx_shift  <= left_tx;
                        hold_r    <= right_tx;
                        tx_req    <= 1'b1;
                        pend_ok   <= 1'b0;
                        frame_err <= (bit_cnt != FULL);
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (sclk_fall) begin
                    rx_arm <= 1'b1;
                    if (tx_cnt != FULL) begin
                        sd_out_q <= tx_shift[DATA_W-1];
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        tx_cnt   <= tx_cnt + 1'b1;
                    end else begin
                        sd_out_q <= 1'b0;
                    end
                end

                if (sclk_rise && rx_arm && (bit_cnt != FULL)) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST) begin
                        if (state == LEFT) begin
                            pend_l  <= rx_next;
                            pend_ok <= 1'b1;
                        end else if (pend_ok) begin
                            // Pair is published together; strobe is
                            // visible alongside the new data.
                            left_rx  <= pend_l;
                            right_rx <= rx_next;
                            rx_valid <= 1'b1;
                            pend_ok  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
